// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM among NREQ pixel requesters: fixed-priority or
// round-robin grant with starvation override, registered issue, tagged return.
module sprite_rom_arbiter #(
  parameter int NREQ         = 4,
  parameter int AW           = 14,
  parameter int DW           = 12,
  parameter int ROM_LAT      = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rr_mode,
  input  logic             hold,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]  req_ready,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_data
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  logic            rom_en_q, rom_en_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [NREQ-1:0] tag_q [ROM_LAT+1];
  logic [NREQ-1:0] tag_d [ROM_LAT+1];

  logic [NREQ-1:0] starve;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            gvalid;

  always_comb begin
    starve = '0;
    for (int k = 0; k < NREQ; k++)
      starve[k] = req_valid[k] && (cnt_q[k] == LIMIT);
  end

  // Descending scans so the lowest index (or nearest to ptr) is written last.
  always_comb begin
    gidx   = '0;
    grant  = '0;
    gvalid = !rst && !hold && (|req_valid);
    if (|starve) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (starve[k]) gidx = PW'(k);
    end else if (!rr_mode) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (req_valid[k]) gidx = PW'(k);
    end else begin
      for (int i = NREQ - 1; i >= 0; i--)
        if (req_valid[(int'(ptr_q) + i) % NREQ])
          gidx = PW'((int'(ptr_q) + i) % NREQ);
    end
    if (gvalid) grant[gidx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gvalid)
      ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
    for (int k = 0; k < NREQ; k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant[k] || !req_valid[k])
        cnt_d[k] = '0;
      else if (!hold && cnt_q[k] != LIMIT)
        cnt_d[k] = cnt_q[k] + CW'(1);
    end
    rom_en_d   = gvalid;
    rom_addr_d = rom_addr_q;
    if (gvalid) rom_addr_d = req_addr[int'(gidx)*AW +: AW];
    tag_d[0] = grant;
    for (int i = 1; i <= ROM_LAT; i++)
      tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= '0;
      for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      for (int k = 0; k < NREQ; k++) cnt_q[k] <= cnt_d[k];
      for (int i = 0; i <= ROM_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign req_ready = grant;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign rsp_valid = tag_q[ROM_LAT];
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table plus random traffic
// checked against a cycle-level reference model and a 1-cycle ROM.
module tb_sprite_rom_arbiter;

  localparam int N   = 4;
  localparam int AW  = 14;
  localparam int DW  = 12;
  localparam int LAT = 1;
  localparam int LIM = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            rr_mode;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(
    .NREQ(N), .AW(AW), .DW(DW), .ROM_LAT(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst), .rr_mode(rr_mode), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[DW-1:0] ^ {a[AW-1:DW], 10'h2A5};
  endfunction

  always @(posedge clk)
    if (rom_en) rom_data <= rom_f(rom_addr);

  typedef struct packed {
    logic [N-1:0]  tag;
    logic [AW-1:0] addr;
  } hist_t;

  typedef struct {
    logic         r, rr, h;
    logic [N-1:0] v, rdy;
    logic         en;
    logic [N-1:0] rsp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int wcnt [N];
  int ptr;
  logic [AW-1:0] m_addr;
  hist_t hq[$];
  vec_t  tab[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int k);
    return req_addr[k*AW +: AW];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) wcnt[k] = 0;
    ptr    = 0;
    m_addr = '0;
    hq.delete();
    for (int i = 0; i <= LAT; i++) hq.push_front('0);
  endtask

  function automatic int pick(input logic r, input logic h,
                              input logic rr, input logic [N-1:0] v);
    if (r || h) return -1;
    for (int k = 0; k < N; k++)
      if (v[k] && wcnt[k] >= LIM) return k;
    if (!rr) begin
      for (int k = 0; k < N; k++)
        if (v[k]) return k;
    end else begin
      for (int i = 0; i < N; i++)
        if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic rr, input logic h,
                       input logic [N-1:0] v, input bit use_tab,
                       input vec_t tv);
    int g;
    logic [N-1:0] er;
    hist_t e;
    rst = r; rr_mode = rr; hold = h; req_valid = v;
    @(negedge clk);
    g  = pick(r, h, rr, v);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    e = hq[LAT];
    check("req_ready", 32'(req_ready), 32'(er));
    check("rom_en", 32'(rom_en), 32'(hq[0].tag != '0));
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("rsp_valid", 32'(rsp_valid), 32'(e.tag));
    if (e.tag != '0)
      check("rsp_data", 32'(rsp_data), 32'(rom_f(e.addr)));
    if (use_tab) begin
      check("tab_ready", 32'(req_ready), 32'(tv.rdy));
      check("tab_rom_en", 32'(rom_en), 32'(tv.en));
      check("tab_rsp_valid", 32'(rsp_valid), 32'(tv.rsp));
    end
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++) begin
        if (k == g || !v[k]) wcnt[k] = 0;
        else if (!h && wcnt[k] < LIM) wcnt[k]++;
      end
      e = '0;
      if (g >= 0) begin
        ptr    = (g + 1) % N;
        m_addr = addr_of(g);
        e.tag  = er;
        e.addr = m_addr;
      end
      hq.push_front(e);
      while (hq.size() > LAT + 1) void'(hq.pop_back());
    end
    #1;
  endtask

  task automatic add(input logic r, input logic rr, input logic h,
                     input logic [N-1:0] v, input logic [N-1:0] rdy,
                     input logic en, input logic [N-1:0] rsp);
    vec_t t;
    t.r = r; t.rr = rr; t.h = h; t.v = v;
    t.rdy = rdy; t.en = en; t.rsp = rsp;
    tab.push_back(t);
  endtask

  initial begin
    logic [N-1:0] rrseq [8];
    logic [N-1:0] rspseq [8];
    vec_t nv;
    nv = '{default: '0};
    rrseq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rspseq = '{4'b0010, 4'b1000, 4'b0001, 4'b0010,
               4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // reset, then starvation in fixed priority
    for (int i = 0; i < 3; i++) add(1, 0, 0, 4'b1111, 4'b0000, 0, 4'b0000);
    add(0, 0, 0, 4'b1111, 4'b0001, 0, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 1, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0001);
    add(0, 0, 0, 4'b1010, 4'b0010, 0, 4'b0000);
    add(0, 0, 0, 4'b1010, 4'b0010, 1, 4'b0000);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 4'b1010, 4'b0010, 1, 4'b0010);
    add(0, 0, 0, 4'b1010, 4'b1000, 1, 4'b0010);
    add(0, 0, 0, 4'b1010, 4'b0010, 1, 4'b0010);
    add(0, 0, 0, 4'b1010, 4'b0010, 1, 4'b1000);
    // round robin from pointer 0
    add(0, 0, 0, 4'b1000, 4'b1000, 1, 4'b0010);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 4'b1111, rrseq[i], 1, rspseq[i]);
    // latency on req2
    add(0, 0, 0, 4'b0000, 4'b0000, 1, 4'b0100);
    add(0, 0, 0, 4'b0000, 4'b0000, 0, 4'b1000);
    add(0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000);
    add(0, 0, 0, 4'b0100, 4'b0100, 0, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 1, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0100);
    // hold with a read in flight
    add(0, 0, 0, 4'b0001, 4'b0001, 0, 4'b0000);
    add(0, 0, 1, 4'b0001, 4'b0000, 1, 4'b0000);
    add(0, 0, 1, 4'b0001, 4'b0000, 0, 4'b0001);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 4'b0001, 4'b0000, 0, 4'b0000);
    add(0, 0, 0, 4'b0011, 4'b0001, 0, 4'b0000);
    // reset with reads in flight
    add(0, 0, 0, 4'b0001, 4'b0001, 1, 4'b0000);
    add(1, 0, 0, 4'b0001, 4'b0000, 1, 4'b0001);
    add(0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000);
    add(0, 0, 0, 4'b0000, 4'b0000, 0, 4'b0000);

    req_addr  = {14'h3D3, 14'h0123, 14'h1B1, 14'h0A0};
    rst       = 1'b1;
    rr_mode   = 1'b0;
    hold      = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    model_reset();

    foreach (tab[i])
      cycle(tab[i].r, tab[i].rr, tab[i].h, tab[i].v, 1'b1, tab[i]);

    // hand sequence: rr_mode flips mid-stream, pointer kept
    cycle(0, 1, 0, 4'b0110, 1'b0, nv);
    cycle(0, 0, 0, 4'b0111, 1'b0, nv);
    cycle(0, 1, 0, 4'b0111, 1'b0, nv);
    cycle(0, 1, 0, 4'b0101, 1'b0, nv);

    for (int c = 0; c < 600; c++) begin
      req_addr = (N*AW)'({$urandom, $urandom});
      cycle($urandom_range(0, 49) == 0, ($urandom_range(0, 15) < 8),
            $urandom_range(0, 4) == 0,
            N'($urandom | $urandom), 1'b0, nv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
